mem_arbiter: RTL and testbench

//  Sequences and shares the single-port data RAM between two requesters: instruction fetch (IF,

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter_load_extend.sv | 27 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the data-RAM arbiter.
//   sizeE   - load/store access size codes (byte/half/word/illegal)
//   stateE  - arbiter FSM states
//   ownerE  - which requester owns the current access
//   lsMisaligned() - true when an LS request must be rejected
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } sizeE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } stateE;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } ownerE;

    // Illegal size code, or address not aligned to the access size.
    function automatic logic lsMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        case (sizeE'(size))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addrLo[0];
            SZ_WORD: bad = (addrLo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core-side (IF and LS requesters) and RAM-side signals of
// the data-RAM arbiter.
//   slave  - arbiter view: takes requests and RAM read data, drives grants,
//            responses and RAM controls
//   master - environment view (core + RAM), the mirror of slave
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    // instruction fetch requester
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [WIDTH-1:0] if_rdata;
    // load/store requester
    logic             ls_req;
    logic             ls_we;
    logic [1:0]       ls_size;
    logic             ls_unsigned;
    logic [WIDTH-1:0] ls_addr;
    logic [WIDTH-1:0] ls_wdata;
    logic             ls_gnt;
    logic             ls_err;
    logic             ls_rvalid;
    logic [WIDTH-1:0] ls_rdata;
    // RAM port
    logic [WIDTH-1:0] ram_wr_data;
    logic [WIDTH-1:0] ram_addr;
    logic             ram_rdEn;
    logic             ram_wrEn;
    logic             ram_isByte;
    logic             ram_isHalf;
    logic             ram_isWord;
    logic [WIDTH-1:0] ram_rd_data;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output ls_gnt, ls_err, ls_rvalid, ls_rdata,
        output ram_wr_data, ram_addr, ram_rdEn, ram_wrEn,
        output ram_isByte, ram_isHalf, ram_isWord,
        input  ram_rd_data
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  ls_gnt, ls_err, ls_rvalid, ls_rdata,
        input  ram_wr_data, ram_addr, ram_rdEn, ram_wrEn,
        input  ram_isByte, ram_isHalf, ram_isWord,
        output ram_rd_data
    );

endinterface

// File: rtl/mem_arbiter_load_extend.sv
// load_extend: combinational sign/zero extension of right-justified RAM
// read data.
//   rdData  in  WIDTH  raw RAM data (byte/half right-justified)
//   size    in  2      access size code
//   zeroExt in  1      1 = zero-extend, 0 = sign-extend
//   extData out WIDTH  extended word
module load_extend
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdData,
    input  sizeE             size,
    input  logic             zeroExt,
    output logic [WIDTH-1:0] extData
);

    always_comb begin
        extData = rdData;
        case (size)
            SZ_BYTE: extData = {{(WIDTH-8){~zeroExt & rdData[7]}}, rdData[7:0]};
            SZ_HALF: extData = {{(WIDTH-16){~zeroExt & rdData[15]}}, rdData[15:0]};
            default: extData = rdData;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data RAM between instruction fetch
// (word reads) and load/store (byte/half/word reads and writes).
//   clk    in  system clock, all state on rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of mem_arbiter_if: IF/LS request-grant-response
//          handshakes and the RAM control/data port
// Round-robin between the two requesters, misaligned LS requests rejected
// without touching RAM, load data sign/zero-extended before return.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_arbiter_if.slave bus
);

    stateE            state;
    ownerE            lastOwner;
    ownerE            curOwner;
    sizeE             curSize;
    logic             curZeroExt;
    logic             curRead;

    ownerE            winner;
    logic             anyReq;
    logic             lsBad;
    logic [WIDTH-1:0] extData;

    load_extend #(
        .WIDTH (WIDTH)
    ) uLoadExtend (
        .rdData  (bus.ram_rd_data),
        .size    (curSize),
        .zeroExt (curZeroExt),
        .extData (extData)
    );

    // On a tie the requester that did not win last time gets the RAM.
    always_comb begin
        anyReq = bus.if_req | bus.ls_req;
        winner = OWN_IF;
        if (bus.if_req && bus.ls_req) begin
            winner = (lastOwner == OWN_LS) ? OWN_IF : OWN_LS;
        end else if (bus.ls_req) begin
            winner = OWN_LS;
        end
        lsBad = lsMisaligned(bus.ls_size, bus.ls_addr[1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            lastOwner       <= OWN_IF;
            curOwner        <= OWN_IF;
            curSize         <= SZ_BYTE;
            curZeroExt      <= 1'b0;
            curRead         <= 1'b0;
            bus.if_gnt      <= 1'b0;
            bus.if_rvalid   <= 1'b0;
            bus.if_rdata    <= '0;
            bus.ls_gnt      <= 1'b0;
            bus.ls_err      <= 1'b0;
            bus.ls_rvalid   <= 1'b0;
            bus.ls_rdata    <= '0;
            bus.ram_wr_data <= '0;
            bus.ram_addr    <= '0;
            bus.ram_rdEn    <= 1'b0;
            bus.ram_wrEn    <= 1'b0;
            bus.ram_isByte  <= 1'b0;
            bus.ram_isHalf  <= 1'b0;
            bus.ram_isWord  <= 1'b0;
        end else begin
            bus.if_gnt    <= 1'b0;
            bus.ls_gnt    <= 1'b0;
            bus.ls_err    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.ls_rvalid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (anyReq) begin
                        lastOwner <= winner;
                        curOwner  <= winner;
                        if (winner == OWN_LS) begin
                            bus.ls_gnt <= 1'b1;
                            if (lsBad) begin
                                // Rejected: acknowledge with error, RAM untouched.
                                bus.ls_err <= 1'b1;
                            end else begin
                                bus.ram_addr    <= bus.ls_addr;
                                bus.ram_wr_data <= bus.ls_wdata;
                                bus.ram_rdEn    <= ~bus.ls_we;
                                bus.ram_wrEn    <= bus.ls_we;
                                bus.ram_isByte  <= (bus.ls_size == SZ_BYTE);
                                bus.ram_isHalf  <= (bus.ls_size == SZ_HALF);
                                bus.ram_isWord  <= (bus.ls_size == SZ_WORD);
                                curSize         <= sizeE'(bus.ls_size);
                                curZeroExt      <= bus.ls_unsigned;
                                curRead         <= ~bus.ls_we;
                                state           <= ST_ACCESS;
                            end
                        end else begin
                            bus.if_gnt     <= 1'b1;
                            bus.ram_addr   <= bus.if_addr;
                            bus.ram_rdEn   <= 1'b1;
                            bus.ram_wrEn   <= 1'b0;
                            bus.ram_isByte <= 1'b0;
                            bus.ram_isHalf <= 1'b0;
                            bus.ram_isWord <= 1'b1;
                            curSize        <= SZ_WORD;
                            curZeroExt     <= 1'b1;
                            curRead        <= 1'b1;
                            state          <= ST_ACCESS;
                        end
                    end
                end

                ST_ACCESS: begin
                    bus.ram_rdEn <= 1'b0;
                    bus.ram_wrEn <= 1'b0;
                    state        <= curRead ? ST_RESP : ST_IDLE;
                end

                ST_RESP: begin
                    if (curOwner == OWN_IF) begin
                        bus.if_rvalid <= 1'b1;
                        bus.if_rdata  <= extData;
                    end else begin
                        bus.ls_rvalid <= 1'b1;
                        bus.ls_rdata  <= extData;
                    end
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int unsigned nAssert;
    int unsigned nFail;
    int unsigned enCount;
    int unsigned enBefore;

    mem_arbiter_if #(.WIDTH(32)) bus ();

    mem_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte-addressed little-endian RAM, read data registered one cycle.
    logic [7:0] mem [0:63];
    always @(posedge clk) begin
        logic [5:0] a;
        a = bus.ram_addr[5:0];
        if (bus.ram_wrEn) begin
            mem[a] <= bus.ram_wr_data[7:0];
            if (!bus.ram_isByte) mem[a + 6'd1] <= bus.ram_wr_data[15:8];
            if (bus.ram_isWord) begin
                mem[a + 6'd2] <= bus.ram_wr_data[23:16];
                mem[a + 6'd3] <= bus.ram_wr_data[31:24];
            end
        end
        if (bus.ram_rdEn) begin
            if (bus.ram_isByte)
                bus.ram_rd_data <= {24'h0, mem[a]};
            else if (bus.ram_isHalf)
                bus.ram_rd_data <= {16'h0, mem[a + 6'd1], mem[a]};
            else
                bus.ram_rd_data <= {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
        end
    end

    always @(negedge clk) begin
        if (bus.ram_rdEn || bus.ram_wrEn) enCount <= enCount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lsIssue(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.ls_we       = we;
        bus.ls_size     = size;
        bus.ls_unsigned = uns;
        bus.ls_addr     = addr;
        bus.ls_wdata    = wdata;
        bus.ls_req      = 1'b1;
        tick();
        bus.ls_req      = 1'b0;
    endtask

    task automatic lsStore(input string tag, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        lsIssue(1'b1, size, 1'b0, addr, wdata);
        check({tag, " gnt"}, {31'h0, bus.ls_gnt}, 32'h1);
        check({tag, " err"}, {31'h0, bus.ls_err}, 32'h0);
        check({tag, " wrEn"}, {31'h0, bus.ram_wrEn}, 32'h1);
        check({tag, " rdEn"}, {31'h0, bus.ram_rdEn}, 32'h0);
        check({tag, " addr"}, bus.ram_addr, addr);
        tick();
        check({tag, " wrEn drop"}, {31'h0, bus.ram_wrEn}, 32'h0);
    endtask

    task automatic lsLoad(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
        lsIssue(1'b0, size, uns, addr, 32'h0);
        check({tag, " gnt"}, {31'h0, bus.ls_gnt}, 32'h1);
        check({tag, " rdEn"}, {31'h0, bus.ram_rdEn}, 32'h1);
        check({tag, " if_gnt"}, {31'h0, bus.if_gnt}, 32'h0);
        tick();
        check({tag, " early rvalid"}, {31'h0, bus.ls_rvalid}, 32'h0);
        tick();
        check({tag, " rvalid"}, {31'h0, bus.ls_rvalid}, 32'h1);
        check({tag, " rdata"}, bus.ls_rdata, exp);
        check({tag, " if_rvalid"}, {31'h0, bus.if_rvalid}, 32'h0);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        nAssert = 0;
        nFail = 0;
        enCount = 0;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.ls_req = 1'b0;
        bus.ls_we = 1'b0;
        bus.ls_size = 2'b00;
        bus.ls_unsigned = 1'b0;
        bus.ls_addr = '0;
        bus.ls_wdata = '0;

        // reset state
        tick();
        tick();
        check("rst if_gnt", {31'h0, bus.if_gnt}, 32'h0);
        check("rst ls_gnt", {31'h0, bus.ls_gnt}, 32'h0);
        check("rst ls_rvalid", {31'h0, bus.ls_rvalid}, 32'h0);
        check("rst ram_rdEn", {31'h0, bus.ram_rdEn}, 32'h0);
        check("rst ram_isWord", {31'h0, bus.ram_isWord}, 32'h0);
        check("rst ram_addr", bus.ram_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        // word store/load round trip; IF side stays quiet
        lsStore("st w8", 2'b10, 32'h8, 32'hDEADBEEF);
        lsStore("st w0", 2'b10, 32'h0, 32'h11223344);
        lsStore("st w4", 2'b10, 32'h4, 32'h55667788);
        lsLoad("ld w8", 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
        check("idle if_rdata", bus.if_rdata, 32'h0);
        tick();
        check("rvalid pulse", {31'h0, bus.ls_rvalid}, 32'h0);
        check("rdata held", bus.ls_rdata, 32'hDEADBEEF);

        // byte/half stores with sign and zero extension
        lsStore("st b4", 2'b00, 32'h4, 32'h00000080);
        check("st b4 isByte", {31'h0, bus.ram_isByte}, 32'h1);
        lsLoad("ld b4 s", 2'b00, 1'b0, 32'h4, 32'hFFFFFF80);
        lsLoad("ld b4 u", 2'b00, 1'b1, 32'h4, 32'h00000080);
        lsStore("st h6", 2'b01, 32'h6, 32'h00008001);
        lsLoad("ld h6 s", 2'b01, 1'b0, 32'h6, 32'hFFFF8001);
        lsLoad("ld h6 u", 2'b01, 1'b1, 32'h6, 32'h00008001);

        // rejects: no RAM enables, one per cycle
        enBefore = enCount;
        lsIssue(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
        check("rej h3 gnt", {31'h0, bus.ls_gnt}, 32'h1);
        check("rej h3 err", {31'h0, bus.ls_err}, 32'h1);
        check("rej h3 rdEn", {31'h0, bus.ram_rdEn}, 32'h0);
        lsIssue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
        check("rej w2 gnt", {31'h0, bus.ls_gnt}, 32'h1);
        check("rej w2 err", {31'h0, bus.ls_err}, 32'h1);
        lsIssue(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678);
        check("rej sz3 gnt", {31'h0, bus.ls_gnt}, 32'h1);
        check("rej sz3 err", {31'h0, bus.ls_err}, 32'h1);
        check("rej sz3 wrEn", {31'h0, bus.ram_wrEn}, 32'h0);
        tick();
        check("rej err pulse", {31'h0, bus.ls_err}, 32'h0);
        check("rej no enables", enCount, enBefore);

        // both requesting from reset: LS, IF, LS, IF
        rst_n = 1'b0;
        bus.ls_we = 1'b0; bus.ls_size = 2'b10; bus.ls_unsigned = 1'b0;
        bus.ls_addr = 32'h8; bus.ls_req = 1'b1;
        bus.if_addr = 32'h0; bus.if_req = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("rr1 ls_gnt", {31'h0, bus.ls_gnt}, 32'h1);
        check("rr1 if_gnt", {31'h0, bus.if_gnt}, 32'h0);
        bus.ls_addr = 32'h4;
        tick();
        tick();
        check("rr1 ls_rvalid", {31'h0, bus.ls_rvalid}, 32'h1);
        check("rr1 ls_rdata", bus.ls_rdata, 32'hDEADBEEF);
        check("rr1 if_rvalid", {31'h0, bus.if_rvalid}, 32'h0);
        tick();
        check("rr2 if_gnt", {31'h0, bus.if_gnt}, 32'h1);
        check("rr2 ls_gnt", {31'h0, bus.ls_gnt}, 32'h0);
        check("rr2 isWord", {31'h0, bus.ram_isWord}, 32'h1);
        bus.if_addr = 32'h4;
        tick();
        tick();
        check("rr2 if_rvalid", {31'h0, bus.if_rvalid}, 32'h1);
        check("rr2 if_rdata", bus.if_rdata, 32'h11223344);
        check("rr2 ls_rvalid", {31'h0, bus.ls_rvalid}, 32'h0);
        tick();
        check("rr3 ls_gnt", {31'h0, bus.ls_gnt}, 32'h1);
        check("rr3 if_gnt", {31'h0, bus.if_gnt}, 32'h0);
        bus.ls_req = 1'b0;
        tick();
        tick();
        check("rr3 ls_rdata", bus.ls_rdata, 32'h80017780);
        check("rr3 ls_rvalid", {31'h0, bus.ls_rvalid}, 32'h1);
        tick();
        check("rr4 if_gnt", {31'h0, bus.if_gnt}, 32'h1);
        bus.if_req = 1'b0;
        tick();
        tick();
        check("rr4 if_rvalid", {31'h0, bus.if_rvalid}, 32'h1);
        check("rr4 if_rdata", bus.if_rdata, 32'h80017780);

        // reset during the ACCESS cycle of a load
        lsIssue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check("ra gnt", {31'h0, bus.ls_gnt}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("ra ls_gnt", {31'h0, bus.ls_gnt}, 32'h0);
        check("ra rdEn", {31'h0, bus.ram_rdEn}, 32'h0);
        check("ra addr", bus.ram_addr, 32'h0);
        check("ra isWord", {31'h0, bus.ram_isWord}, 32'h0);
        bus.ls_addr = 32'h0; bus.ls_req = 1'b1;
        bus.if_addr = 32'h8; bus.if_req = 1'b1;
        tick();
        check("ra no rvalid 1", {31'h0, bus.ls_rvalid}, 32'h0);
        tick();
        check("ra no rvalid 2", {31'h0, bus.ls_rvalid}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("ra ls first", {31'h0, bus.ls_gnt}, 32'h1);
        check("ra if later", {31'h0, bus.if_gnt}, 32'h0);
        check("ra no rvalid 3", {31'h0, bus.ls_rvalid}, 32'h0);
        bus.ls_req = 1'b0;
        tick();
        tick();
        check("ra ls_rdata", bus.ls_rdata, 32'h11223344);
        tick();
        check("ra if_gnt", {31'h0, bus.if_gnt}, 32'h1);
        bus.if_req = 1'b0;
        tick();
        tick();
        check("ra if_rdata", bus.if_rdata, 32'hDEADBEEF);

        // back-to-back IF reads, one access every three cycles
        bus.if_addr = 32'h0;
        bus.if_req = 1'b1;
        tick();
        check("if0 gnt", {31'h0, bus.if_gnt}, 32'h1);
        check("if0 isWord", {31'h0, bus.ram_isWord}, 32'h1);
        check("if0 addr", bus.ram_addr, 32'h0);
        bus.if_addr = 32'h4;
        tick();
        check("if0 rdEn drop", {31'h0, bus.ram_rdEn}, 32'h0);
        check("if0 no gnt", {31'h0, bus.if_gnt}, 32'h0);
        tick();
        check("if0 rvalid", {31'h0, bus.if_rvalid}, 32'h1);
        check("if0 rdata", bus.if_rdata, 32'h11223344);
        check("if0 no gnt2", {31'h0, bus.if_gnt}, 32'h0);
        tick();
        check("if4 gnt", {31'h0, bus.if_gnt}, 32'h1);
        check("if4 rdEn", {31'h0, bus.ram_rdEn}, 32'h1);
        check("if4 isWord", {31'h0, bus.ram_isWord}, 32'h1);
        check("if4 addr", bus.ram_addr, 32'h4);
        bus.if_req = 1'b0;
        tick();
        tick();
        check("if4 rvalid", {31'h0, bus.if_rvalid}, 32'h1);
        check("if4 rdata", bus.if_rdata, 32'h80017780);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
